// File: rtl/cotm32_clint_mh.sv
// Multi-hart core-local interruptor: shared prescaled 64-bit mtime, per-hart msip/mtimecmp,
// 32-bit MMIO slave with byte strobes and a fixed one-cycle registered response.
module cotm32_clint_mh #(
   parameter int          NUM_HARTS = 1,
   parameter int          XLEN      = 32,
   parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
   parameter int          TICK_DIV  = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 req_i,
   input  logic                 we_i,
   input  logic [31:0]          addr_i,
   input  logic [XLEN-1:0]      wdata_i,
   input  logic [XLEN/8-1:0]    wstrb_i,
   output logic [XLEN-1:0]      rdata_o,
   output logic                 rvalid_o,
   output logic                 err_o,
   output logic [NUM_HARTS-1:0] msip_o,
   output logic [NUM_HARTS-1:0] mtip_o
);

   localparam int             PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0]  PRESC_LAST = PW'(TICK_DIV - 1);
   localparam logic [31:0]    NH         = NUM_HARTS;

   // Handshake: every req_i cycle is accepted (no backpressure); rvalid_o pulses exactly
   // one cycle later with err_o and, for reads, rdata_o sampled at the request edge.

   logic [PW-1:0]  r_presc;
   logic [63:0]    r_mtime;
   logic [NUM_HARTS-1:0] r_msip;
   logic [63:0]    r_mtimecmp [NUM_HARTS];
   logic [NUM_HARTS-1:0] r_mtip;
   logic [31:0]    r_rdata;
   logic           r_rvalid;
   logic           r_err;

   logic [31:0]    w_off;
   logic           w_in_win;
   logic           w_aligned;
   logic           w_msip_sel;
   logic           w_cmp_sel;
   logic           w_time_sel;
   logic [11:0]    w_msip_idx;
   logic [12:0]    w_cmp_idx;
   logic           w_msip_ok;
   logic           w_cmp_ok;
   logic           w_fault;
   logic           w_wr;
   logic           w_time_wr;
   logic           w_tick;
   logic           w_msip_bit;
   logic [63:0]    w_cmp_val;
   logic [31:0]    w_rdata;

   function automatic logic [31:0] f_merge(input logic [31:0] old_v,
                                           input logic [31:0] new_v,
                                           input logic [3:0]  strb);
      logic [31:0] res;
      for (int b = 0; b < 4; b++)
         res[8*b +: 8] = strb[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
      return res;
   endfunction

   // Decode: msip at 0x0000.., mtimecmp at 0x4000.., mtime at 0xBFF8; mtime wins any overlap.
   assign w_off      = addr_i - BASE_ADDR;
   assign w_in_win   = (w_off[31:16] == 16'h0000);
   assign w_aligned  = (w_off[1:0] == 2'b00);
   assign w_msip_sel = w_in_win && (w_off[15:14] == 2'b00);
   assign w_time_sel = w_in_win && (w_off[15:3] == 13'h17FF);
   assign w_cmp_sel  = w_in_win && (w_off[15:14] != 2'b00) && (w_off[15:3] < 13'h17FF);
   assign w_msip_idx = w_off[13:2];
   assign w_cmp_idx  = w_off[15:3] - 13'h0800;
   assign w_msip_ok  = w_msip_sel && ({20'd0, w_msip_idx} < NH);
   assign w_cmp_ok   = w_cmp_sel && ({19'd0, w_cmp_idx} < NH);
   assign w_fault    = !w_aligned || !(w_msip_ok || w_cmp_ok || w_time_sel);
   assign w_wr       = req_i && we_i && !w_fault;
   assign w_time_wr  = w_wr && w_time_sel && (|wstrb_i);
   assign w_tick     = (r_presc == PRESC_LAST);

   always_comb begin
      w_msip_bit = 1'b0;
      w_cmp_val  = '0;
      for (int h = 0; h < NUM_HARTS; h++) begin
         if (w_msip_idx == 12'(h)) w_msip_bit = r_msip[h];
         if (w_cmp_idx == 13'(h))  w_cmp_val  = r_mtimecmp[h];
      end
   end

   always_comb begin
      w_rdata = '0;
      if (!w_fault) begin
         if (w_msip_ok)
            w_rdata = {31'd0, w_msip_bit};
         else if (w_time_sel)
            w_rdata = w_off[2] ? r_mtime[63:32] : r_mtime[31:0];
         else if (w_cmp_ok)
            w_rdata = w_off[2] ? w_cmp_val[63:32] : w_cmp_val[31:0];
      end
   end

   // A software write to mtime replaces that cycle's increment; the prescaler keeps running.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_presc <= '0;
         r_mtime <= '0;
      end else begin
         r_presc <= w_tick ? '0 : r_presc + 1'b1;
         if (w_time_wr) begin
            if (w_off[2])
               r_mtime[63:32] <= f_merge(r_mtime[63:32], wdata_i, wstrb_i);
            else
               r_mtime[31:0]  <= f_merge(r_mtime[31:0], wdata_i, wstrb_i);
         end else if (w_tick) begin
            r_mtime <= r_mtime + 64'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_msip <= '0;
         r_mtip <= '0;
         for (int h = 0; h < NUM_HARTS; h++)
            r_mtimecmp[h] <= 64'hFFFF_FFFF_FFFF_FFFF;
      end else begin
         for (int h = 0; h < NUM_HARTS; h++) begin
            if (w_wr && w_msip_ok && (w_msip_idx == 12'(h)) && wstrb_i[0])
               r_msip[h] <= wdata_i[0];
            if (w_wr && w_cmp_ok && (w_cmp_idx == 13'(h))) begin
               if (w_off[2])
                  r_mtimecmp[h][63:32] <= f_merge(r_mtimecmp[h][63:32], wdata_i, wstrb_i);
               else
                  r_mtimecmp[h][31:0]  <= f_merge(r_mtimecmp[h][31:0], wdata_i, wstrb_i);
            end
            r_mtip[h] <= (r_mtime >= r_mtimecmp[h]);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rdata  <= '0;
         r_rvalid <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_rvalid <= req_i;
         r_err    <= req_i && w_fault;
         if (req_i && !we_i)
            r_rdata <= w_rdata;
      end
   end

   assign rdata_o  = r_rdata;
   assign rvalid_o = r_rvalid;
   assign err_o    = r_err;
   assign msip_o   = r_msip;
   assign mtip_o   = r_mtip;

endmodule

// File: tb/tb_cotm32_clint_mh.sv
// Directed bench for cotm32_clint_mh (2 harts, TICK_DIV=4): expected responses are queued
// at issue time and a negedge monitor pops and compares each acknowledged access.
module tb_cotm32_clint_mh;

   localparam logic [31:0] BASE = 32'h0200_0000;

   logic        clk;
   logic        rst_n;
   logic        req_i;
   logic        we_i;
   logic [31:0] addr_i;
   logic [31:0] wdata_i;
   logic [3:0]  wstrb_i;
   logic [31:0] rdata_o;
   logic        rvalid_o;
   logic        err_o;
   logic [1:0]  msip_o;
   logic [1:0]  mtip_o;

   int checks   = 0;
   int errors   = 0;
   int edge_cnt = 0;

   // {check_data, err, data}
   logic [33:0] exp_q[$];
   string       name_q[$];
   int          due_q[$];

   cotm32_clint_mh #(
      .NUM_HARTS(2),
      .XLEN(32),
      .BASE_ADDR(BASE),
      .TICK_DIV(4)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .req_i(req_i),
      .we_i(we_i),
      .addr_i(addr_i),
      .wdata_i(wdata_i),
      .wstrb_i(wstrb_i),
      .rdata_o(rdata_o),
      .rvalid_o(rvalid_o),
      .err_o(err_o),
      .msip_o(msip_o),
      .mtip_o(mtip_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) if (rst_n) edge_cnt++;

   initial begin
      #200000;
      $display("FAIL watchdog expired at edge %0d", edge_cnt);
      $fatal(1, "watchdog");
   end

   always @(negedge clk) begin
      if (rst_n) begin
         if (due_q.size() > 0 && due_q[0] <= edge_cnt) begin
            logic [33:0] e;
            string       nm;
            int          d;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            d  = due_q.pop_front();
            checks++;
            if (rvalid_o !== 1'b1) begin
               errors++;
               $display("FAIL %s: rvalid=%b at edge %0d, required 1 (due %0d)", nm, rvalid_o, edge_cnt, d);
            end else if (err_o !== e[32] || (e[33] && rdata_o !== e[31:0])) begin
               errors++;
               $display("FAIL %s: err=%b rdata=%08h, required err=%b rdata=%08h%s",
                        nm, err_o, rdata_o, e[32], e[31:0], e[33] ? "" : " (data not checked)");
            end
         end else if (rvalid_o !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rvalid: rvalid=%b at edge %0d, required 0", rvalid_o, edge_cnt);
         end
      end
   end

   task automatic access(input string nm, input logic we, input logic [15:0] off,
                         input logic [31:0] wd, input logic [3:0] st,
                         input logic exp_err, input logic [31:0] exp_data);
      req_i   = 1'b1;
      we_i    = we;
      addr_i  = BASE + {16'h0000, off};
      wdata_i = wd;
      wstrb_i = st;
      exp_q.push_back({!we, exp_err, exp_data});
      name_q.push_back(nm);
      due_q.push_back(edge_cnt + 1);
      @(negedge clk);
      req_i   = 1'b0;
      we_i    = 1'b0;
      wstrb_i = 4'h0;
   endtask

   task automatic check_val(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %08h, required %08h (edge %0d)", nm, act, exp, edge_cnt);
      end
   endtask

   // Returns at the negedge just before active edge number e.
   task automatic at_edge(input int e);
      while (edge_cnt < e - 1) @(negedge clk);
      if (edge_cnt != e - 1) begin
         checks++;
         errors++;
         $display("FAIL schedule: at edge %0d, required %0d", edge_cnt, e - 1);
      end
   endtask

   initial begin
      rst_n   = 1'b0;
      req_i   = 1'b0;
      we_i    = 1'b0;
      addr_i  = '0;
      wdata_i = '0;
      wstrb_i = '0;
      repeat (3) @(negedge clk);
      check_val("rst_rvalid", {31'd0, rvalid_o}, 32'd0);
      rst_n = 1'b1;
      check_val("rst_rdata", rdata_o, 32'd0);
      check_val("rst_err", {31'd0, err_o}, 32'd0);
      check_val("rst_msip", {30'd0, msip_o}, 32'd0);
      check_val("rst_mtip", {30'd0, mtip_o}, 32'd0);

      access("cmp0_lo_reset", 1'b0, 16'h4000, 32'h0, 4'h0, 1'b0, 32'hFFFF_FFFF);
      access("cmp0_hi_reset", 1'b0, 16'h4004, 32'h0, 4'h0, 1'b0, 32'hFFFF_FFFF);
      check_val("mtip_after_reset", {30'd0, mtip_o}, 32'd0);

      at_edge(41);
      access("mtime_lo_40cyc", 1'b0, 16'hBFF8, 32'h0, 4'h0, 1'b0, 32'd10);
      access("wr_cmp0_lo", 1'b1, 16'h4000, 32'd12, 4'hF, 1'b0, 32'h0);
      access("wr_cmp0_hi", 1'b1, 16'h4004, 32'd0, 4'hF, 1'b0, 32'h0);
      at_edge(49);
      check_val("mtip_at_12", {30'd0, mtip_o}, 32'd0);
      @(negedge clk);
      check_val("mtip_rise", {30'd0, mtip_o}, 32'd1);

      access("wr_mtime_hi", 1'b1, 16'hBFFC, 32'd0, 4'hF, 1'b0, 32'h0);
      access("wr_mtime_lo", 1'b1, 16'hBFF8, 32'hFFFF_FFFF, 4'hF, 1'b0, 32'h0);
      at_edge(53);
      access("carry_hi", 1'b0, 16'hBFFC, 32'h0, 4'h0, 1'b0, 32'd1);
      access("carry_lo", 1'b0, 16'hBFF8, 32'h0, 4'h0, 1'b0, 32'd0);

      at_edge(56);
      access("wr_lo_on_tick", 1'b1, 16'hBFF8, 32'h55, 4'hF, 1'b0, 32'h0);
      access("tick_collide_lo", 1'b0, 16'hBFF8, 32'h0, 4'h0, 1'b0, 32'h55);
      access("tick_collide_hi", 1'b0, 16'hBFFC, 32'h0, 4'h0, 1'b0, 32'd1);
      access("wr_cmp0_hi_big", 1'b1, 16'h4004, 32'hFFFF_FFFF, 4'hF, 1'b0, 32'h0);
      check_val("mtip_hold", {30'd0, mtip_o}, 32'd1);
      @(negedge clk);
      check_val("mtip_clear", {30'd0, mtip_o}, 32'd0);

      access("wr_msip1", 1'b1, 16'h0004, 32'hFFFF_FFFF, 4'hF, 1'b0, 32'h0);
      check_val("msip_after_wr", {30'd0, msip_o}, 32'd2);
      access("wr_msip_hart2", 1'b1, 16'h0008, 32'hFFFF_FFFF, 4'hF, 1'b1, 32'h0);
      check_val("msip_unchanged", {30'd0, msip_o}, 32'd2);
      access("rd_msip0", 1'b0, 16'h0000, 32'h0, 4'h0, 1'b0, 32'd0);
      access("rd_msip1", 1'b0, 16'h0004, 32'h0, 4'h0, 1'b0, 32'd1);
      access("rd_misaligned", 1'b0, 16'h0002, 32'h0, 4'h0, 1'b1, 32'd0);
      access("wr_cmp1_byte", 1'b1, 16'h4008, 32'h0000_00AB, 4'h1, 1'b0, 32'h0);
      access("rd_cmp1_lo", 1'b0, 16'h4008, 32'h0, 4'h0, 1'b0, 32'hFFFF_FFAB);
      access("rd_cmp1_hi", 1'b0, 16'h400C, 32'h0, 4'h0, 1'b0, 32'hFFFF_FFFF);
      access("rd_cmp0_lo", 1'b0, 16'h4000, 32'h0, 4'h0, 1'b0, 32'd12);
      access("rd_cmp_hart2", 1'b0, 16'h4010, 32'h0, 4'h0, 1'b1, 32'd0);
      access("rd_unmapped", 1'b0, 16'hC000, 32'h0, 4'h0, 1'b1, 32'd0);
      access("wr_strb0", 1'b1, 16'h0004, 32'h0, 4'h0, 1'b0, 32'h0);
      check_val("msip_strb0", {30'd0, msip_o}, 32'd2);
      access("wr_msip0", 1'b1, 16'h0000, 32'h1, 4'h1, 1'b0, 32'h0);
      check_val("msip_both", {30'd0, msip_o}, 32'd3);
      access("rd_msip0_set", 1'b0, 16'h0000, 32'h0, 4'h0, 1'b0, 32'd1);

      repeat (3) @(negedge clk);
      check_val("queue_drained", due_q.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
